// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: start detect, bit timing,
// LSB-first deserialise, parity/stop check, result pulses.
//
// Ports:
//   CLK          oversampling clock (Prescale x bit rate)
//   RST          synchronous active-low reset
//   RX_IN        synchronised serial line, idle high
//   Prescale     oversampling ratio (8 or 16)
//   PAR_EN       a parity bit follows the data bits
//   PAR_TYP      0 = even parity, 1 = odd parity
//   sampled_bit  majority-voted bit from the sampler
//   edge_cnt     oversample edge index within the bit
//   data_samp_en sampler enable (high while in a frame)
//   P_DATA       received byte, updated with data_valid
//   data_valid   1-cycle pulse, good frame
//   par_err      1-cycle pulse, parity mismatch
//   stp_err      1-cycle pulse, stop bit sampled low
module uart_rx_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_IN,
    input  logic [5:0]        Prescale,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              sampled_bit,
    output logic [5:0]        edge_cnt,
    output logic              data_samp_en,
    output logic [DATA_W-1:0] P_DATA,
    output logic              data_valid,
    output logic              par_err,
    output logic              stp_err
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]        state;
    logic [5:0]        ps_q;
    logic              pe_q;
    logic              pt_q;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              par_flag;
    logic [5:0]        ps_last;
    logic              bit_end;

    // Prescale of 0 gives ps_last = 63, so the counter
    // still wraps and the frame still terminates.
    assign ps_last = ps_q - 6'd1;
    assign bit_end = (edge_cnt == ps_last);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state        <= IDLE;
            ps_q         <= '0;
            pe_q         <= 1'b0;
            pt_q         <= 1'b0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            par_flag     <= 1'b0;
            edge_cnt     <= '0;
            data_samp_en <= 1'b0;
            P_DATA       <= '0;
            data_valid   <= 1'b0;
            par_err      <= 1'b0;
            stp_err      <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            case (state)
                IDLE: begin
                    edge_cnt     <= '0;
                    data_samp_en <= 1'b0;
                    if (!RX_IN) begin
                        state        <= START;
                        ps_q         <= Prescale;
                        pe_q         <= PAR_EN;
                        pt_q         <= PAR_TYP;
                        data_samp_en <= 1'b1;
                    end
                end
                START, DATA, PARITY, STOP: begin
                    data_samp_en <= 1'b1;
                    edge_cnt     <= bit_end ? 6'd0 : edge_cnt + 6'd1;
                    if (bit_end) begin
                        case (state)
                            START: begin
                                if (sampled_bit) begin
                                    // glitch: drop silently
                                    state        <= IDLE;
                                    data_samp_en <= 1'b0;
                                end else begin
                                    state   <= DATA;
                                    bit_cnt <= '0;
                                end
                            end
                            DATA: begin
                                shift_reg[bit_cnt] <= sampled_bit;
                                if (bit_cnt == LAST_BIT) begin
                                    state <= pe_q ? PARITY : STOP;
                                end else begin
                                    bit_cnt <= bit_cnt + CNT_ONE;
                                end
                            end
                            PARITY: begin
                                par_flag <= (sampled_bit !=
                                    (pt_q ? ~^shift_reg : ^shift_reg));
                                state    <= STOP;
                            end
                            default: begin
                                state        <= IDLE;
                                data_samp_en <= 1'b0;
                                par_flag     <= 1'b0;
                                par_err      <= par_flag;
                                stp_err      <= ~sampled_bit;
                                if (!par_flag && sampled_bit) begin
                                    data_valid <= 1'b1;
                                    P_DATA     <= shift_reg;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    state        <= IDLE;
                    edge_cnt     <= '0;
                    data_samp_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
